// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams instruction words into memory, from address 0 upward
// Optionally pads the unused tail of memory with a fill word.
module instr_loader #(
  parameter int                DATA_W    = 9,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter int                FILL_EN   = 1,
  parameter logic [DATA_W-1:0] FILL_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_FILL);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LOAD;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            ptr        <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_en      <= 1'b1;
            wr_addr    <= ptr;
            wr_data    <= in_data;
            word_count <= word_count + 1'b1;
            // ptr saturates at the top address so it never wraps within a load
            if (ptr != LAST_ADDR) ptr <= ptr + 1'b1;
            if (in_last) begin
              if ((ptr != LAST_ADDR) && (FILL_EN != 0)) begin
                state <= S_FILL;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else if (ptr == LAST_ADDR) begin
              state    <= S_ERR;
              overflow <= 1'b1;
            end
          end
        end
        S_FILL: begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= FILL_WORD;
          if (ptr == LAST_ADDR) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed bench for instr_loader
// Two instances share the inputs: u0 has padding off, u1 has padding on.
module tb_instr_loader;
  localparam int DW = 9;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic rdy0, we0, busy0, done0, ovf0;
  logic rdy1, we1, busy1, done1, ovf1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic [AW:0] wc0, wc1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int nw0 = 0, nw1 = 0, bad0 = 0, bad1 = 0;
  logic [AW-1:0] prev0 = '0, prev1 = '0;
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  int wcyc1 [DEPTH];

  instr_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FILL_EN(0), .FILL_WORD(9'h1FF)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy0), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0),
    .busy(busy0), .done(done0), .overflow(ovf0), .word_count(wc0));

  instr_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FILL_EN(1), .FILL_WORD(9'h1FF)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy1), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1),
    .busy(busy1), .done(done1), .overflow(ovf1), .word_count(wc1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // write monitors; an address must follow the previous one or restart at 0
  always @(negedge clk) begin
    if (we0) begin
      if (nw0 > 0 && wa0 != AW'(prev0 + 1'b1) && wa0 != '0) bad0 <= bad0 + 1;
      prev0 <= wa0;
      mem0[wa0] <= wd0;
      nw0 <= nw0 + 1;
    end
    if (we1) begin
      if (nw1 > 0 && wa1 != AW'(prev1 + 1'b1) && wa1 != '0) bad1 <= bad1 + 1;
      prev1 <= wa1;
      mem1[wa1] <= wd1;
      wcyc1[wa1] <= cyc;
      nw1 <= nw1 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic v, input logic [DW-1:0] d, input logic l, output logic acc);
    in_valid = v;
    in_data = d;
    in_last = l;
    acc = v && rdy1;
    tick();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy0 || busy1) && t < 600) begin
      tick();
      t++;
    end
    checks++;
    if (busy0 || busy1) begin
      failures++;
      $display("FAIL %s_timeout busy0=%0b busy1=%0b required 0", name, busy0, busy1);
    end
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({rdy0, we0, wa0, wd0, busy0, done0, ovf0, wc0} !== '0) begin
      failures++;
      $display("FAIL reset_u0 outputs=%h required 0", {rdy0, we0, wa0, wd0, busy0, done0, ovf0, wc0});
    end
    checks++;
    if ({rdy1, we1, wa1, wd1, busy1, done1, ovf1, wc1} !== '0) begin
      failures++;
      $display("FAIL reset_u1 outputs=%h required 0", {rdy1, we1, wa1, wd1, busy1, done1, ovf1, wc1});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_three_beats();
    logic acc;
    int base0 = nw0;
    int base1 = nw1;
    pulse_start();
    checks++;
    if (rdy0 !== 1'b1 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL load_entry in_ready=%b busy=%b required 1 1", rdy0, busy0);
    end
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, DW'(i + 1), i == 2, acc);
      checks++;
      if (acc !== 1'b1 || we0 !== 1'b1 || wa0 !== AW'(i) || wd0 !== DW'(i + 1)) begin
        failures++;
        $display("FAIL beat%0d acc=%b wr_en=%b addr=%0d data=%h required 1 1 %0d %h",
                 i, acc, we0, wa0, wd0, i, i + 1);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (we0 !== 1'b0 || done0 !== 1'b1 || wc0 !== 9'd3 || busy0 !== 1'b0 || rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL nofill_done wr_en=%b done=%b count=%0d busy=%b ready=%b required 0 1 3 0 0",
               we0, done0, wc0, busy0, rdy0);
    end
    checks++;
    if (busy1 !== 1'b1 || rdy1 !== 1'b0 || we1 !== 1'b1 || wd1 !== 9'h1FF) begin
      failures++;
      $display("FAIL fill_active busy=%b ready=%b wr_en=%b data=%h required 1 0 1 1ff", busy1, rdy1, we1, wd1);
    end
    wait_idle("fill");
    begin
      int bad_fill = 0;
      for (int a = 3; a < DEPTH; a++) if (mem1[a] !== 9'h1FF) bad_fill++;
      checks++;
      if (bad_fill != 0 || mem1[0] !== 9'h001 || mem1[1] !== 9'h002 || mem1[2] !== 9'h003) begin
        failures++;
        $display("FAIL fill_content bad_fill=%0d m0=%h m1=%h m2=%h required 0 001 002 003",
                 bad_fill, mem1[0], mem1[1], mem1[2]);
      end
    end
    checks++;
    if (nw1 - base1 != 256 || wcyc1[255] - wcyc1[3] != 252 || wcyc1[3] - wcyc1[2] != 1) begin
      failures++;
      $display("FAIL fill_timing writes=%0d span=%0d gap=%0d required 256 252 1",
               nw1 - base1, wcyc1[255] - wcyc1[3], wcyc1[3] - wcyc1[2]);
    end
    checks++;
    if (done1 !== 1'b1 || wc1 !== 9'd3 || ovf1 !== 1'b0 || we1 !== 1'b0 || nw0 - base0 != 3) begin
      failures++;
      $display("FAIL fill_done done=%b count=%0d ovf=%b wr_en=%b u0_writes=%0d required 1 3 0 0 3",
               done1, wc1, ovf1, we1, nw0 - base0);
    end
  endtask

  task automatic test_overflow();
    logic acc;
    int n_acc = 0;
    int base1 = nw1;
    int bb = bad1;
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      drive_beat(1'b1, DW'(i * 3), 1'b0, acc);
      if (acc) n_acc++;
    end
    checks++;
    if (we1 !== 1'b1 || wa1 !== 8'd255 || wd1 !== DW'(255 * 3) || ovf1 !== 1'b1 || ovf0 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_last_write wr_en=%b addr=%0d data=%h ovf1=%b ovf0=%b required 1 255 %h 1 1",
               we1, wa1, wd1, ovf1, ovf0, DW'(255 * 3));
    end
    idle_inputs();
    tick();
    checks++;
    if (n_acc != 256 || rdy1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || wc1 !== 9'd256) begin
      failures++;
      $display("FAIL ovf_state acc=%0d ready=%b busy=%b done=%b count=%0d required 256 0 0 0 256",
               n_acc, rdy1, busy1, done1, wc1);
    end
    checks++;
    if (nw1 - base1 != 256 || bad1 != bb || we1 !== 1'b0 || ovf1 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_writes writes=%0d badseq=%0d wr_en=%b ovf=%b required 256 0 0 1",
               nw1 - base1, bad1 - bb, we1, ovf1);
    end
  endtask

  task automatic test_full_last();
    logic acc;
    int base1 = nw1;
    pulse_start();
    checks++;
    if (ovf1 !== 1'b0 || wc1 !== 9'd0) begin
      failures++;
      $display("FAIL restart_clear ovf=%b count=%0d required 0 0", ovf1, wc1);
    end
    for (int i = 0; i < 256; i++) drive_beat(1'b1, DW'(511 - i), i == 255, acc);
    idle_inputs();
    tick();
    tick();
    checks++;
    if (done1 !== 1'b1 || ovf1 !== 1'b0 || wc1 !== 9'd256 || we1 !== 1'b0 || nw1 - base1 != 256 || mem1[255] !== 9'd256) begin
      failures++;
      $display("FAIL full_last done=%b ovf=%b count=%0d wr_en=%b writes=%0d m255=%0d required 1 0 256 0 256 256",
               done1, ovf1, wc1, we1, nw1 - base1, mem1[255]);
    end
  endtask

  task automatic test_gaps();
    logic acc;
    logic [DW-1:0] exp_d [20];
    int n_acc = 0;
    int t = 0;
    int base0 = nw0;
    int bb = bad0;
    int bad_data = 0;
    pulse_start();
    while (n_acc < 20 && t < 400) begin
      logic v;
      logic [DW-1:0] d;
      v = 1'($urandom_range(0, 1));
      d = DW'($urandom);
      drive_beat(v, d, v && n_acc == 19, acc);
      if (acc) begin
        exp_d[n_acc] = d;
        n_acc++;
      end
      t++;
    end
    idle_inputs();
    wait_idle("gaps");
    for (int k = 0; k < 20; k++) if (mem0[k] !== exp_d[k]) bad_data++;
    checks++;
    if (n_acc != 20 || nw0 - base0 != 20 || bad0 != bb || bad_data != 0) begin
      failures++;
      $display("FAIL gaps accepted=%0d writes=%0d badseq=%0d baddata=%0d required 20 20 0 0",
               n_acc, nw0 - base0, bad0 - bb, bad_data);
    end
    checks++;
    if (done0 !== 1'b1 || wc0 !== 9'd20 || done1 !== 1'b1 || wc1 !== 9'd20) begin
      failures++;
      $display("FAIL gaps_done done0=%b count0=%0d done1=%b count1=%0d required 1 20 1 20",
               done0, wc0, done1, wc1);
    end
  endtask

  task automatic test_reset_in_fill();
    logic acc;
    int t = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) drive_beat(1'b1, DW'(i + 7), i == 2, acc);
    idle_inputs();
    while (!(we1 && wa1 == 8'd100) && t < 300) begin
      tick();
      t++;
    end
    checks++;
    if (!(we1 && wa1 == 8'd100)) begin
      failures++;
      $display("FAIL fill_reach100 wr_en=%b addr=%0d required 1 100", we1, wa1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rdy1, we1, wa1, wd1, busy1, done1, ovf1, wc1} !== '0) begin
      failures++;
      $display("FAIL async_reset outputs=%h required 0", {rdy1, we1, wa1, wd1, busy1, done1, ovf1, wc1});
    end
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 9'h055;
    in_last = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (we1 !== 1'b0 || rdy1 !== 1'b1 || wc1 !== 9'd0) begin
      failures++;
      $display("FAIL start_with_valid wr_en=%b ready=%b count=%0d required 0 1 0", we1, rdy1, wc1);
    end
    drive_beat(1'b1, 9'h055, 1'b1, acc);
    checks++;
    if (acc !== 1'b1 || we1 !== 1'b1 || wa1 !== 8'd0 || wd1 !== 9'h055) begin
      failures++;
      $display("FAIL restart_addr0 acc=%b wr_en=%b addr=%0d data=%h required 1 1 0 055", acc, we1, wa1, wd1);
    end
    idle_inputs();
    wait_idle("restart");
  endtask

  initial begin
    test_reset();
    test_three_beats();
    test_overflow();
    test_full_last();
    test_gaps();
    test_reset_in_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
